// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_x_b;

  assign a_x_b = a ^ b;
  assign d     = a_x_b ^ bin;
  assign bout  = (~a & b) | (~a_x_b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell with a registered borrow.
// Optional signed-overflow output under `SERIAL_SUB_OVF_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; diff/borrow hold last result
// ST_SHIFT | one bit per cycle for WIDTH cycles
// ST_DONE  | one-cycle done pulse, then back to idle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, diff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               br_q, busy_q, done_q, borrow_q;
  logic               bit_d, br_d;
  logic [WIDTH-1:0]   res_d;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (br_d)
  );

  assign res_d = {bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      a_msb_q <= a_in[WIDTH-1];
      b_msb_q <= b_in[WIDTH-1];
    end else if (state_q == ST_SHIFT && cnt_q == CNT_W'(WIDTH - 1)) begin
      // Final bit is the result MSB
      ovf_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            diff_q   <= res_d;
            borrow_q <= br_d;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse of the lab's combinational adders: subtraction instead of addition, and sequential instead of combinational. It trades WIDTH+1 cycles of latency for one-bit datapath area, and sits behind a simple start/done handshake so a testbench or controller can issue operations back to back.

## Interface
- `WIDTH`, default 8: operand and result width; legal range ≥ 2.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the rising edge while high.
- `start` in 1: request; sampled only in IDLE.
- `a_in` in WIDTH: minuend; captured on the edge that accepts `start`.
- `b_in` in WIDTH: subtrahend; captured on the same edge.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; `diff`/`borrow` are valid from this cycle onward.
- `diff` out WIDTH: `a - b` mod 2^WIDTH; held until the next completion.
- `borrow` out 1: 1 iff unsigned `a < b`; held with `diff`.
- `ovf` out 1: present only under `SERIAL_SUB_OVF_EN`; signed (two's-complement) overflow.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 loads the operand shift registers from `a_in`/`b_in` and clears the running borrow, bit counter and result shift register; next state is SHIFT.
  - `start`=0 stays in IDLE.
- SHIFT, each cycle:
  - `d = a0 ^ b0 ^ br`
  - `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - `d` enters the MSB of the result shift register; both operand registers shift right by one; the counter increments.
- After WIDTH SHIFT cycles:
  - The result shift register is copied to `diff` and the final `br` to `borrow`.
  - `done` goes high and the state moves to DONE.
- DONE lasts exactly one cycle; `done` drops and the state returns to IDLE.
- `start` while `busy`=1 (SHIFT or DONE) is ignored; there is no queuing.
- `diff`/`borrow` never change mid-operation. They update only on completion.
- Counter width is `$clog2(WIDTH+1)`. Arithmetic is modulo 2^WIDTH, and the borrow out of the MSB is reported, never dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0; state IDLE.
- Call the edge that accepts `start` edge 0. The SHIFT bit operations occur on edges 1..WIDTH. `done`=1 and the new `diff` are visible after edge WIDTH, for one cycle.
- Issue interval: a new `start` is accepted no earlier than the cycle after DONE, i.e. WIDTH+2 cycles per operation.
- Reset mid-operation aborts the operation. All outputs return to their reset values on that edge, and a `start` in the cycle after reset deasserts is accepted.
- Reset overrides `start` when both are high.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - On completion, `ovf = (a_msb != b_msb) && (diff_msb != a_msb)`, using the captured operand MSBs, which are held in dedicated flops.
  - `ovf` is held with `diff` and cleared by reset.
- `SERIAL_SUB_OVF_EN` undefined: there is no `ovf` port and no MSB capture flops. All other behaviour is identical.

## Structure
- Shared package/header `serial_sub_pkg`: state encodings `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2, plus the default WIDTH.
- Sub-module `full_subtractor` (A, B, Bin → D, Bout) is purely combinational, gate-level in the same style as the lab adders, and instanced once.
- Top level: FSM, counter, operand/result shift registers, borrow flop, output registers.

## Test plan
All scenarios use WIDTH=8.
- `a`=100, `b`=37, `start` pulse → `diff`=63, `borrow`=0; `done` high exactly one cycle, after edge 8.
- `a`=5, `b`=10 → `diff`=8'hFB, `borrow`=1.
- `a`=8'h80, `b`=8'h01 with `SERIAL_SUB_OVF_EN` → `diff`=8'h7F, `borrow`=0, `ovf`=1. Then `a`=8'h10, `b`=8'h01 → `ovf`=0.
- `a`=200, `b`=50, then `start` re-pulsed with `a`=1, `b`=1 on edge 3 → ignored; `diff`=150, single `done`.
- `reset` raised on edge 4 of an operation → all outputs 0 next cycle. A new `start` (`a`=9, `b`=3) right after → `diff`=6.
- `a`=`b`=8'hFF, then a second `start` in the first IDLE cycle after DONE with `a`=0, `b`=1 → `diff`=0/`borrow`=0, then `diff`=8'hFF/`borrow`=1.
